// File: rtl/cw305_axi_pkg.sv
// Shared definitions for the CW305 AXI4-Lite host and the mailbox responder:
// mailbox layout, fixed AXI fields and state encodings.
package cw305_axi_pkg;

   localparam logic [31:0] MBOX_PT_OFS       = 32'h0000_0000;
   localparam logic [31:0] MBOX_DOORBELL_OFS = 32'h0000_0010;
   localparam logic [31:0] MBOX_STATUS_OFS   = 32'h0000_0014;
   localparam logic [31:0] MBOX_CT_OFS       = 32'h0000_0020;
   localparam logic [31:0] DOORBELL_GO       = 32'h0000_0001;

   localparam logic [2:0]  AXI_PROT          = 3'b000;
   localparam logic [3:0]  AXI_STRB          = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_PT, ST_WR_GO, ST_POLL, ST_RD_CT, ST_DONE, ST_ABORT
   } host_state_e;

   typedef enum logic [1:0] {
      PS_IDLE, PS_WR, PS_RD
   } port_state_e;

   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [31:0] ofs,
                                             input logic [1:0]  idx);
      return base + ofs + {28'h000_0000, idx, 2'b00};
   endfunction

endpackage

// File: rtl/cw305_axi_host_port.sv
// Single-transaction AXI4-Lite initiator: one write or read per req, done pulses
// for one cycle after the B or R handshake. All AXI outputs are registered.
module axi_lite_master_port
   import cw305_axi_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        done,
   output logic [31:0] rdata,
   output logic        mem_axi_awvalid,
   input  logic        mem_axi_awready,
   output logic [31:0] mem_axi_awaddr,
   output logic [2:0]  mem_axi_awprot,
   output logic        mem_axi_wvalid,
   input  logic        mem_axi_wready,
   output logic [31:0] mem_axi_wdata,
   output logic [3:0]  mem_axi_wstrb,
   input  logic        mem_axi_bvalid,
   output logic        mem_axi_bready,
   output logic        mem_axi_arvalid,
   input  logic        mem_axi_arready,
   output logic [31:0] mem_axi_araddr,
   output logic [2:0]  mem_axi_arprot,
   input  logic        mem_axi_rvalid,
   output logic        mem_axi_rready,
   input  logic [31:0] mem_axi_rdata
);

   port_state_e state_r;
   port_state_e state_nx_s;

   assign mem_axi_awprot = AXI_PROT;
   assign mem_axi_arprot = AXI_PROT;
   assign mem_axi_wstrb  = AXI_STRB;

   // Engine state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r <= PS_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Transaction ends on the response handshake of its own direction.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         PS_IDLE: begin
            if (req) begin
               state_nx_s = we ? PS_WR : PS_RD;
            end else begin
               state_nx_s = PS_IDLE;
            end
         end
         PS_WR: begin
            if (mem_axi_bvalid && mem_axi_bready) begin
               state_nx_s = PS_IDLE;
            end else begin
               state_nx_s = PS_WR;
            end
         end
         PS_RD: begin
            if (mem_axi_rvalid && mem_axi_rready) begin
               state_nx_s = PS_IDLE;
            end else begin
               state_nx_s = PS_RD;
            end
         end
         default: state_nx_s = PS_IDLE;
      endcase
   end

   // Channel handshakes: each valid drops independently on its own handshake.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         done            <= 1'b0;
         rdata           <= 32'h0;
         mem_axi_awvalid <= 1'b0;
         mem_axi_awaddr  <= 32'h0;
         mem_axi_wvalid  <= 1'b0;
         mem_axi_wdata   <= 32'h0;
         mem_axi_bready  <= 1'b0;
         mem_axi_arvalid <= 1'b0;
         mem_axi_araddr  <= 32'h0;
         mem_axi_rready  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            PS_IDLE: begin
               if (req && we) begin
                  mem_axi_awvalid <= 1'b1;
                  mem_axi_awaddr  <= addr;
                  mem_axi_wvalid  <= 1'b1;
                  mem_axi_wdata   <= wdata;
                  mem_axi_bready  <= 1'b1;
               end else if (req) begin
                  mem_axi_arvalid <= 1'b1;
                  mem_axi_araddr  <= addr;
               end
            end
            PS_WR: begin
               if (mem_axi_awvalid && mem_axi_awready) mem_axi_awvalid <= 1'b0;
               if (mem_axi_wvalid && mem_axi_wready)   mem_axi_wvalid  <= 1'b0;
               if (mem_axi_bvalid && mem_axi_bready) begin
                  mem_axi_bready <= 1'b0;
                  done           <= 1'b1;
               end
            end
            PS_RD: begin
               if (mem_axi_arvalid && mem_axi_arready) begin
                  mem_axi_arvalid <= 1'b0;
                  mem_axi_rready  <= 1'b1;
               end
               if (mem_axi_rvalid && mem_axi_rready) begin
                  mem_axi_rready <= 1'b0;
                  rdata          <= mem_axi_rdata;
                  done           <= 1'b1;
               end
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/cw305_axi_host.sv
// CW305 register bridge: pushes plaintext into the mailbox, rings the doorbell,
// polls for completion and returns the ciphertext on ct.
module cw305_axi_host
   import cw305_axi_pkg::*;
#(
   parameter logic [31:0] MBOX_BASE  = 32'h0000_0400,
   parameter int          POLL_LIMIT = 1024
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start,
   input  logic [127:0] pt,
   output logic [127:0] ct,
   output logic         busy,
   output logic         error,
   output logic         mem_axi_awvalid,
   input  logic         mem_axi_awready,
   output logic [31:0]  mem_axi_awaddr,
   output logic [2:0]   mem_axi_awprot,
   output logic         mem_axi_wvalid,
   input  logic         mem_axi_wready,
   output logic [31:0]  mem_axi_wdata,
   output logic [3:0]   mem_axi_wstrb,
   input  logic         mem_axi_bvalid,
   output logic         mem_axi_bready,
   output logic         mem_axi_arvalid,
   input  logic         mem_axi_arready,
   output logic [31:0]  mem_axi_araddr,
   output logic [2:0]   mem_axi_arprot,
   input  logic         mem_axi_rvalid,
   output logic         mem_axi_rready,
   input  logic [31:0]  mem_axi_rdata
);

   localparam int CNT_W = $clog2(POLL_LIMIT + 1);
   localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_LIMIT - 1);

   host_state_e      state_r;
   host_state_e      state_nx_s;
   logic [1:0]       idx_r;
   logic [CNT_W-1:0] poll_cnt_r;
   logic [127:0]     pt_r;
   logic [127:0]     shadow_r;
   logic             pending_r;
   logic             req_s;
   logic             we_s;
   logic [31:0]      addr_s;
   logic [31:0]      wdata_s;
   logic             done_s;
   logic [31:0]      rdata_s;

   axi_lite_master_port u_port (
      .clk             (clk),
      .resetn          (resetn),
      .req             (req_s),
      .we              (we_s),
      .addr            (addr_s),
      .wdata           (wdata_s),
      .done            (done_s),
      .rdata           (rdata_s),
      .mem_axi_awvalid (mem_axi_awvalid),
      .mem_axi_awready (mem_axi_awready),
      .mem_axi_awaddr  (mem_axi_awaddr),
      .mem_axi_awprot  (mem_axi_awprot),
      .mem_axi_wvalid  (mem_axi_wvalid),
      .mem_axi_wready  (mem_axi_wready),
      .mem_axi_wdata   (mem_axi_wdata),
      .mem_axi_wstrb   (mem_axi_wstrb),
      .mem_axi_bvalid  (mem_axi_bvalid),
      .mem_axi_bready  (mem_axi_bready),
      .mem_axi_arvalid (mem_axi_arvalid),
      .mem_axi_arready (mem_axi_arready),
      .mem_axi_araddr  (mem_axi_araddr),
      .mem_axi_arprot  (mem_axi_arprot),
      .mem_axi_rvalid  (mem_axi_rvalid),
      .mem_axi_rready  (mem_axi_rready),
      .mem_axi_rdata   (mem_axi_rdata)
   );

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // A request is raised once per transaction; pending_r blocks reissue until done.
   always_comb begin
      state_nx_s = state_r;
      req_s      = 1'b0;
      we_s       = 1'b0;
      addr_s     = MBOX_BASE;
      wdata_s    = 32'h0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_WR_PT;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_WR_PT: begin
            req_s   = !pending_r;
            we_s    = 1'b1;
            addr_s  = word_addr(MBOX_BASE, MBOX_PT_OFS, idx_r);
            wdata_s = pt_r[32*idx_r +: 32];
            if (done_s && (idx_r == 2'd3)) begin
               state_nx_s = ST_WR_GO;
            end else begin
               state_nx_s = ST_WR_PT;
            end
         end
         ST_WR_GO: begin
            req_s   = !pending_r;
            we_s    = 1'b1;
            addr_s  = MBOX_BASE + MBOX_DOORBELL_OFS;
            wdata_s = DOORBELL_GO;
            if (done_s) begin
               state_nx_s = ST_POLL;
            end else begin
               state_nx_s = ST_WR_GO;
            end
         end
         ST_POLL: begin
            req_s  = !pending_r;
            addr_s = MBOX_BASE + MBOX_STATUS_OFS;
            if (done_s && rdata_s[0]) begin
               state_nx_s = ST_RD_CT;
            end else if (done_s && (poll_cnt_r == POLL_LAST)) begin
               state_nx_s = ST_ABORT;
            end else begin
               state_nx_s = ST_POLL;
            end
         end
         ST_RD_CT: begin
            req_s  = !pending_r;
            addr_s = word_addr(MBOX_BASE, MBOX_CT_OFS, idx_r);
            if (done_s && (idx_r == 2'd3)) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_RD_CT;
            end
         end
         ST_DONE:  state_nx_s = ST_IDLE;
         ST_ABORT: state_nx_s = ST_IDLE;
         default:  state_nx_s = ST_IDLE;
      endcase
   end

   // Datapath: captured plaintext, ct shadow, counters and user-visible flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pending_r  <= 1'b0;
         idx_r      <= 2'd0;
         poll_cnt_r <= '0;
         pt_r       <= 128'h0;
         shadow_r   <= 128'h0;
         ct         <= 128'h0;
         busy       <= 1'b0;
         error      <= 1'b0;
      end else begin
         if (req_s) begin
            pending_r <= 1'b1;
         end else if (done_s) begin
            pending_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  pt_r       <= pt;
                  error      <= 1'b0;
                  busy       <= 1'b1;
                  idx_r      <= 2'd0;
                  poll_cnt_r <= '0;
               end
            end
            ST_WR_PT: begin
               if (done_s) idx_r <= idx_r + 2'd1;
            end
            ST_POLL: begin
               if (done_s && !rdata_s[0]) poll_cnt_r <= poll_cnt_r + CNT_W'(1);
            end
            ST_RD_CT: begin
               if (done_s) begin
                  shadow_r[32*idx_r +: 32] <= rdata_s;
                  idx_r                    <= idx_r + 2'd1;
               end
            end
            ST_DONE: begin
               ct   <= shadow_r;
               busy <= 1'b0;
            end
            ST_ABORT: begin
               busy  <= 1'b0;
               error <= 1'b1;
            end
            default: begin
               busy <= busy;
            end
         endcase
      end
   end

endmodule
